// File: rtl/multi_pulse_counter_pkg.sv
// Shared types and helpers for the windowed multi-channel pulse counter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package multi_pulse_counter_pkg;

    // Top-level control state: IDLE holds everything cleared, RUN counts.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter behaviour on an increment at full scale.
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // What a channel counter does this cycle.
    typedef enum logic [1:0] {
        CNT_HOLD  = 2'd0,
        CNT_INCR  = 2'd1,
        CNT_CLEAR = 2'd2
    } cnt_op_t;

    typedef struct packed {
        cnt_op_t op;
        logic    ovf;
    } cnt_dec_t;

    // Decide the counter's next value and whether this cycle overflows.
    // Kept width-agnostic: the caller supplies "already at max" so one
    // function serves every counter width.
    function automatic cnt_dec_t cnt_decide(input logic inc,
                                            input logic at_max,
                                            input logic sat);
        cnt_dec_t d;
        d.op  = CNT_HOLD;
        d.ovf = 1'b0;
        if (inc) begin
            if (at_max) begin
                d.ovf = 1'b1;
                d.op  = sat ? CNT_HOLD : CNT_CLEAR;
            end else begin
                d.op  = CNT_INCR;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/multi_pulse_counter_chan.sv
// One pulse-counter channel: counts strobes, sticky overflow, sat/wrap at full scale.
// Latency: inc -> cnt 1 cycle; cnt_nxt/ovf_nxt are the combinational post-increment view.
// Backpressure: none; every strobe while counting is taken, clr/take zero the state.
module pulse_cnt_chan
    import multi_pulse_counter_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int SAT_MODE = MODE_SAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             take,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             ovf,
    output logic             ovf_nxt
);

    cnt_dec_t dec;

    // Next count and overflow including this cycle's strobe; the top snapshots these on the terminal cycle.
    always_comb begin
        dec     = cnt_decide(inc, (cnt == {CNT_W{1'b1}}), (SAT_MODE != MODE_WRAP));
        cnt_nxt = cnt;
        case (dec.op)
            CNT_INCR:  cnt_nxt = cnt + CNT_W'(1);
            CNT_CLEAR: cnt_nxt = '0;
            default:   cnt_nxt = cnt;
        endcase
        ovf_nxt = ovf | dec.ovf;
    end

    // Counter and sticky overflow; a window boundary restarts from zero so the boundary pulse lands only in the snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr || take) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
        end
    end

endmodule

// File: rtl/multi_pulse_counter.sv
// Windowed N-channel pulse counter: counts strobes per channel, snapshots and clears at each window end.
// Latency: pulse_in -> live_cnt 1 cycle; terminal cycle -> snap_valid/snap_data 1 cycle.
// Backpressure: none; snap_valid is a one-cycle strobe, the reader must sample it when it fires.
module multi_pulse_counter
    import multi_pulse_counter_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int WIN_W    = 24,
    parameter int SAT_MODE = MODE_SAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture_en,
    input  logic [N_CH-1:0]       pulse_in,
    input  logic [WIN_W-1:0]      win_len,
    output logic [N_CH*CNT_W-1:0] live_cnt,
    output logic [N_CH*CNT_W-1:0] snap_data,
    output logic [N_CH-1:0]       snap_ovf,
    output logic                  snap_valid,
    output logic [WIN_W-1:0]      win_timer,
    output logic                  busy
);

    state_t                  state;
    state_t                  state_nxt;
    logic                    count_en;
    logic                    terminal;
    logic                    take;
    logic                    load_len;
    logic [WIN_W-1:0]        win_len_q;
    logic [N_CH*CNT_W-1:0]   cnt_nxt_bus;
    logic [N_CH-1:0]         ovf_bus;
    logic [N_CH-1:0]         ovf_nxt_bus;

    // A zero window length means free-running: no terminal cycle ever.
    assign terminal = (win_len_q != '0) && (win_timer == (win_len_q - WIN_W'(1)));

    // Control FSM: next state plus the per-cycle count/snapshot/load decisions.
    always_comb begin
        state_nxt = state;
        count_en  = 1'b0;
        take      = 1'b0;
        load_len  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (capture_en) begin
                    state_nxt = RUN;
                    load_len  = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (capture_en) begin
                    count_en = 1'b1;
                    take     = terminal;
                    load_len = terminal;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Window timer and latched window length; a new length only takes effect at RUN entry or a boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_timer <= '0;
            win_len_q <= '0;
        end else begin
            if (load_len) begin
                win_len_q <= win_len;
            end
            if (!count_en || take) begin
                win_timer <= '0;
            end else begin
                win_timer <= win_timer + WIN_W'(1);
            end
        end
    end

    // Snapshot registers: hold the last complete window until the next boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_data  <= '0;
            snap_ovf   <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= take;
            if (take) begin
                snap_data <= cnt_nxt_bus;
                snap_ovf  <= ovf_nxt_bus;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        pulse_cnt_chan #(
            .CNT_W    (CNT_W),
            .SAT_MODE (SAT_MODE)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .clr     (!count_en),
            .take    (take),
            .inc     (count_en && pulse_in[i]),
            .cnt     (live_cnt[i*CNT_W +: CNT_W]),
            .cnt_nxt (cnt_nxt_bus[i*CNT_W +: CNT_W]),
            .ovf     (ovf_bus[i]),
            .ovf_nxt (ovf_nxt_bus[i])
        );
    end

endmodule

// File: tb/tb_multi_pulse_counter.sv
// Bench for multi_pulse_counter: saturating and wrapping instances driven in lockstep against a cycle model.
// Latency: n/a.
// Backpressure: n/a.
module tb_multi_pulse_counter;

    localparam int N_CH  = 4;
    localparam int CNT_W = 4;
    localparam int WIN_W = 8;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  o;
    } snap_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             capture_en = 1'b0;
    logic [N_CH-1:0]  pulse_in = '0;
    logic [WIN_W-1:0] win_len = '0;

    logic [15:0]      live_s, live_w, snapd_s, snapd_w;
    logic [3:0]       snapo_s, snapo_w;
    logic             sv_s, sv_w, busy_s, busy_w;
    logic [WIN_W-1:0] tmr_s, tmr_w;

    int checks = 0;
    int failures = 0;

    // Reference model state (index 0 = saturating, 1 = wrapping).
    int    m_state = 0;
    int    m_timer = 0;
    int    m_wlq = 0;
    int    m_cnt[2][4];
    bit    m_ovf[2][4];
    int    m_snap[2][4];
    bit    m_snovf[2][4];
    bit    m_sv = 0;
    snap_t q_sat[$];
    snap_t q_wrap[$];

    always #5 clk = ~clk;

    multi_pulse_counter #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SAT_MODE(1)) dut_sat (
        .clk(clk), .rst(rst), .capture_en(capture_en), .pulse_in(pulse_in), .win_len(win_len),
        .live_cnt(live_s), .snap_data(snapd_s), .snap_ovf(snapo_s), .snap_valid(sv_s),
        .win_timer(tmr_s), .busy(busy_s)
    );

    multi_pulse_counter #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SAT_MODE(0)) dut_wrap (
        .clk(clk), .rst(rst), .capture_en(capture_en), .pulse_in(pulse_in), .win_len(win_len),
        .live_cnt(live_w), .snap_data(snapd_w), .snap_ovf(snapo_w), .snap_valid(sv_w),
        .win_timer(tmr_w), .busy(busy_w)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] pack_live(input int k);
        logic [15:0] r;
        for (int c = 0; c < 4; c++) r[c*4 +: 4] = 4'(m_cnt[k][c]);
        return r;
    endfunction

    function automatic logic [15:0] pack_snap(input int k);
        logic [15:0] r;
        for (int c = 0; c < 4; c++) r[c*4 +: 4] = 4'(m_snap[k][c]);
        return r;
    endfunction

    function automatic logic [3:0] pack_snovf(input int k);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = m_snovf[k][c];
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_timer = 0; m_wlq = 0; m_sv = 0;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++) begin
                m_cnt[k][c] = 0; m_ovf[k][c] = 0; m_snap[k][c] = 0; m_snovf[k][c] = 0;
            end
        q_sat.delete();
        q_wrap.delete();
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit    en, term, ov;
        int    nv;
        snap_t s;
        en   = (m_state == 1) && capture_en;
        term = en && (m_wlq != 0) && (m_timer == m_wlq - 1);
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                nv = m_cnt[k][c];
                ov = 0;
                if (pulse_in[c]) begin
                    if (nv == 15) begin
                        ov = 1;
                        nv = (k == 0) ? 15 : 0;
                    end else begin
                        nv = nv + 1;
                    end
                end
                if (!en) begin
                    m_cnt[k][c] = 0; m_ovf[k][c] = 0;
                end else if (term) begin
                    m_snap[k][c]  = nv;
                    m_snovf[k][c] = m_ovf[k][c] | ov;
                    m_cnt[k][c] = 0; m_ovf[k][c] = 0;
                end else begin
                    m_cnt[k][c] = nv;
                    m_ovf[k][c] = m_ovf[k][c] | ov;
                end
            end
        end
        if (term) begin
            s.d = pack_snap(0); s.o = pack_snovf(0); q_sat.push_back(s);
            s.d = pack_snap(1); s.o = pack_snovf(1); q_wrap.push_back(s);
        end
        m_sv = term;
        if (m_state == 0 && capture_en) m_wlq = int'(win_len);
        else if (term) m_wlq = int'(win_len);
        if (!en || term) m_timer = 0;
        else m_timer = (m_timer + 1) % 256;
        m_state = capture_en ? 1 : 0;
    endtask

    task automatic compare_all();
        snap_t e;
        chk("busy_sat", busy_s, m_state);
        chk("busy_wrap", busy_w, m_state);
        chk("timer_sat", tmr_s, m_timer);
        chk("timer_wrap", tmr_w, m_timer);
        chk("live_sat", live_s, pack_live(0));
        chk("live_wrap", live_w, pack_live(1));
        chk("valid_sat", sv_s, m_sv);
        chk("valid_wrap", sv_w, m_sv);
        chk("snapd_sat", snapd_s, pack_snap(0));
        chk("snapd_wrap", snapd_w, pack_snap(1));
        chk("snapo_sat", snapo_s, pack_snovf(0));
        chk("snapo_wrap", snapo_w, pack_snovf(1));
        if (sv_s) begin
            if (q_sat.size() == 0) chk("sb_sat_unexpected", 1, 0);
            else begin
                e = q_sat.pop_front();
                chk("sb_sat_data", snapd_s, e.d);
                chk("sb_sat_ovf", snapo_s, e.o);
            end
        end
        if (sv_w) begin
            if (q_wrap.size() == 0) chk("sb_wrap_unexpected", 1, 0);
            else begin
                e = q_wrap.pop_front();
                chk("sb_wrap_data", snapd_w, e.d);
                chk("sb_wrap_ovf", snapo_w, e.o);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_live", live_s, 0);
        chk("rst_snap", snapd_s, 0);
        chk("rst_busy", busy_s, 0);
        chk("rst_valid", sv_w, 0);
        @(negedge clk);
        rst = 1'b0;

        // Disabled: pulses must be ignored.
        for (int i = 0; i < 8; i++) begin
            pulse_in = 4'($urandom);
            step();
        end

        // win_len=10 with the mixed channel pattern.
        win_len = 8'd10;
        capture_en = 1'b1;
        for (int i = 0; i < 31; i++) begin
            pulse_in[0] = 1'b1;
            pulse_in[1] = (m_timer % 2 == 0);
            pulse_in[2] = 1'b0;
            pulse_in[3] = (m_state == 1) && (m_timer == m_wlq - 1);
            step();
            if (i == 10) begin
                chk("tp_win10_valid", sv_s, 1);
                chk("tp_win10_data", snapd_s, 16'h105A);
            end
            if (i == 11) chk("tp_win10_restart", live_w, 16'h0011);
        end

        // Overflow over a 20-cycle window, then a clean window.
        capture_en = 1'b0; step();
        win_len = 8'd20; capture_en = 1'b1; pulse_in = 4'b0001;
        step();
        repeat (20) step();
        chk("tp_sat_ch0", snapd_s[3:0], 4'd15);
        chk("tp_sat_ovf", snapo_s[0], 1);
        chk("tp_wrap_ch0", snapd_w[3:0], 4'd4);
        chk("tp_wrap_ovf", snapo_w[0], 1);
        for (int i = 0; i < 20; i++) begin
            pulse_in = (i < 3) ? 4'b0010 : 4'b0000;
            step();
        end
        chk("tp_clean_ovf", snapo_s, 0);
        chk("tp_clean_data", snapd_w, 16'h0030);

        // Capture dropped mid-window.
        capture_en = 1'b0; step();
        win_len = 8'd8; capture_en = 1'b1; pulse_in = 4'b0001;
        step();
        repeat (5) step();
        chk("tp_drop_pre_cnt", live_s, 16'h0005);
        chk("tp_drop_pre_tmr", tmr_s, 5);
        capture_en = 1'b0; step();
        chk("tp_drop_valid", sv_s, 0);
        chk("tp_drop_live", live_w, 0);
        chk("tp_drop_hold", snapd_s, 16'h0030);
        capture_en = 1'b1; step();
        repeat (7) step();
        chk("tp_reen_early", sv_s, 0);
        step();
        chk("tp_reen_valid", sv_s, 1);
        chk("tp_reen_data", snapd_w, 16'h0008);

        // Window length changed mid-window.
        capture_en = 1'b0; step();
        win_len = 8'd10; capture_en = 1'b1;
        pulse_in = 4'($urandom); step();
        for (int i = 0; i < 3; i++) begin pulse_in = 4'($urandom); step(); end
        win_len = 8'd4;
        for (int i = 0; i < 7; i++) begin pulse_in = 4'($urandom); step(); end
        chk("tp_len_old", sv_s, 1);
        for (int i = 0; i < 4; i++) begin pulse_in = 4'($urandom); step(); end
        chk("tp_len_new", sv_w, 1);
        for (int i = 0; i < 9; i++) begin pulse_in = 4'($urandom); step(); end

        // Free-running window.
        win_len = 8'd0;
        capture_en = 1'b0; step();
        capture_en = 1'b1; step();
        for (int i = 0; i < 256; i++) begin pulse_in = 4'($urandom); step(); end
        chk("tp_free_wrap", tmr_s, 0);
        for (int i = 0; i < 20; i++) begin pulse_in = 4'($urandom); step(); end

        // One-cycle windows.
        capture_en = 1'b0; step();
        win_len = 8'd1; capture_en = 1'b1; step();
        for (int i = 0; i < 10; i++) begin
            pulse_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            step();
            chk("tp_w1_valid", sv_s, 1);
            chk("tp_w1_ch0", snapd_w[3:0], (i % 2 == 0) ? 1 : 0);
        end

        // Asynchronous reset mid-run.
        pulse_in = 4'b1111;
        step(); step();
        #2;
        rst = 1'b1;
        #1;
        chk("tp_arst_live", live_s, 0);
        chk("tp_arst_snap", snapd_w, 0);
        chk("tp_arst_ovf", snapo_s, 0);
        chk("tp_arst_valid", sv_s, 0);
        chk("tp_arst_tmr", tmr_w, 0);
        chk("tp_arst_busy", busy_s, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        capture_en = 1'b0;
        win_len = 8'd3;
        step();
        capture_en = 1'b1;
        for (int i = 0; i < 8; i++) begin pulse_in = 4'($urandom); step(); end

        chk("sb_sat_drain", q_sat.size(), 0);
        chk("sb_wrap_drain", q_wrap.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
